// File: rtl/camera_window_writer.sv
// camera_window_writer: keeps camera pixels inside the centred window and feeds them to the write FIFO via a skid buffer (WR_DECIMATE_EN adds 2:1 decimation per axis)
module camera_window_writer #(
  parameter int H_ACT       = 800,
  parameter int V_ACT       = 600,
  parameter int H_WIN_START = 208,
  parameter int V_WIN_START = 108,
  parameter int WIN_W       = 384,
  parameter int WIN_H       = 384,
  parameter int BUF_DEPTH   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic       i_sof,
  input  logic [9:0] i_Red,
  input  logic [9:0] i_Green,
  input  logic [9:0] i_Blue,
  input  logic       i_wfull,
  output logic       o_write_request,
  output logic [9:0] o_Red,
  output logic [9:0] o_Green,
  output logic [9:0] o_Blue,
  output logic       o_frame_done,
  output logic       o_overflow
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [12:0] HL = 13'(H_ACT - 1);
  localparam logic [12:0] VL = 13'(V_ACT - 1);
  localparam logic [12:0] HS = 13'(H_WIN_START);
  localparam logic [12:0] HE = 13'(H_WIN_START + WIN_W);
  localparam logic [12:0] VS = 13'(V_WIN_START);
  localparam logic [12:0] VE = 13'(V_WIN_START + WIN_H);
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);
  typedef enum logic {S_IDLE, S_ACTIVE} state_t;
  state_t state_q, state_d;
  logic [12:0] x_q, x_d, y_q, y_d, px, py;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [29:0] mem_q [BUF_DEPTH];
  logic [29:0] mem_d [BUF_DEPTH];
  logic done_q, done_d, ovf_q, ovf_d;
  logic sof, acc, last, keep, pop, push;
  // pixel position, window test, skid-buffer push/pop and next-state logic
  always_comb begin
    sof = i_valid && i_sof;
    acc = sof || (i_valid && state_q == S_ACTIVE);
    px = sof ? '0 : x_q;
    py = sof ? '0 : y_q;
    last = acc && px == HL && py == VL;
    keep = acc && px >= HS && px < HE && py >= VS && py < VE
`ifdef WR_DECIMATE_EN
      && !(px[0] ^ HS[0]) && !(py[0] ^ VS[0])
`endif
      ;
    pop = cnt_q != '0 && !i_wfull;
    push = keep && (cnt_q != FULL || pop);
    state_d = last ? S_IDLE : acc ? S_ACTIVE : state_q;
    x_d = !acc ? x_q : (last || px == HL) ? '0 : px + 13'd1;
    y_d = !acc ? y_q : last ? '0 : px == HL ? py + 13'd1 : py;
    wr_d = push ? wr_q + PW'(1) : wr_q;
    rd_d = pop ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    mem_d = mem_q;
    if (push) mem_d[wr_q] = {i_Red, i_Green, i_Blue};
    done_d = last;
    ovf_d = (sof ? 1'b0 : ovf_q) | (keep && !push);
    o_write_request = pop;
    {o_Red, o_Green, o_Blue} = mem_q[rd_q];
    o_frame_done = done_q;
    o_overflow = ovf_q;
  end
  // state, counters and buffer registers; reset discards buffered pixels
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      x_q <= '0;
      y_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      mem_q <= '{default: '0};
      done_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
    end
  end
endmodule
